// File: rtl/hls_deadlock_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the
// HLS deadlock reporter slice.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUSPECT  = 2'd1,
    DETECTED = 2'd2
  } state_t;

  localparam int N_CH_DEF      = 7;
  localparam int THRESHOLD_DEF = 1024;
  localparam int CNT_W_DEF     = 16;
  localparam int TS_W_DEF      = 32;

  // Callers zero-extend into 64 bits and truncate the result back.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] limit);
    if (value >= limit) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/hls_deadlock_sat_counter.sv
// Width-parameterised up-counter with clear and enable; SATURATE selects
// sticking at all-ones versus wrapping modulo 2^WIDTH.
module hls_deadlock_sat_counter
  import hls_deadlock_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (en) begin
      if (SATURATE) begin
        count_d = WIDTH'(sat_inc(64'(count_q), 64'(MAX_VAL)));
      end else begin
        count_d = count_q + WIDTH'(1'b1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hls_deadlock_reporter.sv
// Persistence filter, sticky deadlock flag, irq pulse and per-channel snapshot.
// Optional cycle stamp of declaration: HLS_DEADLOCK_REPORTER_TIMESTAMP_EN.
module hls_deadlock_reporter
  import hls_deadlock_pkg::*;
#(
  parameter int N_CH      = N_CH_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int CNT_W     = CNT_W_DEF
`ifdef HLS_DEADLOCK_REPORTER_TIMESTAMP_EN
  ,
  parameter int TS_W      = TS_W_DEF
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block_in,
  input  logic [N_CH-1:0]  axis_block_sigs,
  input  logic             clear,
  output logic             deadlock_detected,
  output logic             deadlock_irq,
  output logic [N_CH-1:0]  snapshot,
  output logic [CNT_W-1:0] stall_cycles
`ifdef HLS_DEADLOCK_REPORTER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  timestamp
`endif
);

  state_t           state_q, state_d;
  logic             detected_q, detected_d;
  logic             irq_q, irq_d;
  logic [N_CH-1:0]  snapshot_q, snapshot_d;
  logic             stall_clr_s;
  logic             stall_en_s;
  logic [CNT_W-1:0] stall_cnt_s;
  logic             threshold_hit_s;

  // The counter already holds THRESHOLD-1 when the final qualifying cycle arrives.
  assign threshold_hit_s = (stall_cnt_s == CNT_W'(THRESHOLD - 1));

  hls_deadlock_sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b1)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (stall_clr_s),
    .en    (stall_en_s),
    .count (stall_cnt_s)
  );

  // Next-state, snapshot and counter control; clear overrides everything.
  always_comb begin
    state_d     = state_q;
    detected_d  = detected_q;
    irq_d       = 1'b0;
    snapshot_d  = snapshot_q;
    stall_clr_s = 1'b0;
    stall_en_s  = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      detected_d  = 1'b0;
      snapshot_d  = {N_CH{1'b0}};
      stall_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (block_in) begin
            state_d    = SUSPECT;
            stall_en_s = 1'b1;
            snapshot_d = axis_block_sigs;
          end else begin
            stall_clr_s = 1'b1;
          end
        end
        SUSPECT: begin
          if (!block_in) begin
            state_d     = IDLE;
            stall_clr_s = 1'b1;
            snapshot_d  = {N_CH{1'b0}};
          end else if (threshold_hit_s) begin
            state_d    = DETECTED;
            stall_en_s = 1'b1;
            detected_d = 1'b1;
            irq_d      = 1'b1;
            snapshot_d = snapshot_q | axis_block_sigs;
          end else begin
            stall_en_s = 1'b1;
            snapshot_d = snapshot_q | axis_block_sigs;
          end
        end
        DETECTED: begin
          if (block_in) begin
            stall_en_s = 1'b1;
          end else begin
            stall_en_s = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          detected_d  = 1'b0;
          snapshot_d  = {N_CH{1'b0}};
          stall_clr_s = 1'b1;
        end
      endcase
    end
  end

  // State and report registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      detected_q <= 1'b0;
      irq_q      <= 1'b0;
      snapshot_q <= {N_CH{1'b0}};
    end else begin
      state_q    <= state_d;
      detected_q <= detected_d;
      irq_q      <= irq_d;
      snapshot_q <= snapshot_d;
    end
  end

  assign deadlock_detected = detected_q;
  assign deadlock_irq      = irq_q;
  assign snapshot          = snapshot_q;
  assign stall_cycles      = stall_cnt_s;

`ifdef HLS_DEADLOCK_REPORTER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_s;
  logic [TS_W-1:0] ts_q, ts_d;

  hls_deadlock_sat_counter #(
    .WIDTH    (TS_W),
    .SATURATE (1'b0)
  ) u_ts_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (1'b0),
    .en    (1'b1),
    .count (ts_cnt_s)
  );

  // Stamp the value the free-running counter takes on the declaring edge.
  always_comb begin
    ts_d = ts_q;
    if (clear) begin
      ts_d = {TS_W{1'b0}};
    end else if (irq_d) begin
      ts_d = ts_cnt_s + TS_W'(1'b1);
    end else begin
      ts_d = ts_q;
    end
  end

  // Timestamp register.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= {TS_W{1'b0}};
    end else begin
      ts_q <= ts_d;
    end
  end

  assign timestamp = ts_q;
`endif

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Scoreboard bench: directed scenarios then random traffic, checked against
// a run-length reference model of the reporter.
module tb_hls_deadlock_reporter;

  localparam int N_CH      = 7;
  localparam int THRESHOLD = 8;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             block_in = 1'b0;
  logic [N_CH-1:0]  axis_block_sigs = '0;
  logic             clear = 1'b0;
  logic             deadlock_detected;
  logic             deadlock_irq;
  logic [N_CH-1:0]  snapshot;
  logic [CNT_W-1:0] stall_cycles;
`ifdef HLS_DEADLOCK_REPORTER_TIMESTAMP_EN
  logic [31:0]      timestamp;
`endif

  hls_deadlock_reporter #(
    .N_CH      (N_CH),
    .THRESHOLD (THRESHOLD),
    .CNT_W     (CNT_W)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .block_in          (block_in),
    .axis_block_sigs   (axis_block_sigs),
    .clear             (clear),
    .deadlock_detected (deadlock_detected),
    .deadlock_irq      (deadlock_irq),
    .snapshot          (snapshot),
    .stall_cycles      (stall_cycles)
`ifdef HLS_DEADLOCK_REPORTER_TIMESTAMP_EN
    ,
    .timestamp         (timestamp)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        det;
    logic        irq;
    logic [6:0]  snap;
    logic [3:0]  stall;
    logic [31:0] ts;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: run length of block_in, sticky report, edge count.
  bit        m_det, m_irq;
  bit [6:0]  m_snap;
  int        m_stall;
  int        m_cyc;
  bit [31:0] m_ts;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic step(input bit rst, input bit blk, input bit [6:0] ax, input bit clr);
    exp_t e;
    @(negedge clock);
    reset = rst; block_in = blk; axis_block_sigs = ax; clear = clr;
    if (rst) begin
      m_det = 0; m_irq = 0; m_snap = '0; m_stall = 0; m_ts = '0; m_cyc = 0;
    end else begin
      m_cyc++;
      m_irq = 0;
      if (clr) begin
        m_det = 0; m_snap = '0; m_stall = 0; m_ts = '0;
      end else if (m_det) begin
        if (blk && m_stall < CNT_MAX) m_stall++;
      end else if (blk) begin
        m_stall++;
        m_snap |= ax;
        if (m_stall == THRESHOLD) begin
          m_det = 1; m_irq = 1; m_ts = 32'(m_cyc);
        end
      end else begin
        m_stall = 0; m_snap = '0;
      end
    end
    e.det = m_det; e.irq = m_irq; e.snap = m_snap; e.stall = 4'(m_stall); e.ts = m_ts;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per clock edge, sampled just after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("deadlock_detected", 32'(deadlock_detected), 32'(e.det));
      chk("deadlock_irq", 32'(deadlock_irq), 32'(e.irq));
      chk("snapshot", 32'(snapshot), 32'(e.snap));
      chk("stall_cycles", 32'(stall_cycles), 32'(e.stall));
`ifdef HLS_DEADLOCK_REPORTER_TIMESTAMP_EN
      chk("timestamp", timestamp, e.ts);
`endif
    end
  end

  initial begin
    bit blk;
    step(1, 0, 7'h00, 0);
    step(1, 0, 7'h00, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 7'h00, 0);
    // Long block: declaration, snapshot accumulation, saturation, no repeat irq.
    for (int i = 0; i < 3; i++) step(0, 1, 7'h01, 0);
    for (int i = 0; i < 105; i++) step(0, 1, 7'h04, 0);
    step(0, 0, 7'h10, 0);
    step(0, 0, 7'h00, 0);
    // Clear in DETECTED with block still high, then re-detection.
    step(0, 1, 7'h02, 1);
    for (int i = 0; i < 12; i++) step(0, 1, 7'h02, 0);
    step(0, 0, 7'h00, 1);
    step(0, 0, 7'h00, 0);
    // Seven-cycle pulse must not declare.
    for (int i = 0; i < 7; i++) step(0, 1, 7'h40, 0);
    step(0, 0, 7'h00, 0);
    step(0, 0, 7'h00, 0);
    // Clear on the threshold-hit cycle.
    for (int i = 0; i < 7; i++) step(0, 1, 7'h08, 0);
    step(0, 1, 7'h08, 1);
    step(0, 0, 7'h00, 0);
    // Reset mid-SUSPECT.
    for (int i = 0; i < 4; i++) step(0, 1, 7'h20, 0);
    step(1, 1, 7'h20, 0);
    step(0, 0, 7'h00, 0);
    // Random traffic with sticky block runs, rare clears and resets.
    blk = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8) blk = ~blk;
      step(($urandom_range(0, 299) == 0), blk, 7'($urandom_range(0, 127)),
           ($urandom_range(0, 39) == 0));
    end
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
